ball_direction_ctrl: RTL and testbench
======================================

BALL_DIRECTION_CTRL -- requirements
Module: ball_direction_ctrl

Interface
REQ-001 SHALL have port CLK_DRV  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port VBLANK  input  1  vertical blank level; its rising edge is the frame update point.
REQ-004 SHALL have port SERVE  input  1  one-cycle pulse requesting a new ball.
REQ-005 SHALL have port MISS  input  1  one-cycle pulse: ball left the playfield.
REQ-006 SHALL have port BRICK_HIT, PADDLE_HIT, TOP_HIT, WALL_L, WALL_R  input  1 each  one-cycle collision pulses.
REQ-007 SHALL have port PADDLE_ZONE  input  2  paddle segment hit (0 far left .. 3 far right), valid with PADDLE_HIT.
REQ-008 SHALL have port CX0, CX1, X2  output  1 each  horizontal load code {X2,CX1,CX0} for the ball motion counters.
REQ-009 SHALL have port Y0, Y1, Y2  output  1 each  vertical load code {Y2,Y1,Y0}.
REQ-010 SHALL have port BALL_EN  output  1  high while a ball is in play.
REQ-011 SHALL have port HIT_COUNT  output  4  saturating paddle-hit count.

Function
REQ-012 SHALL implement FSM states IDLE, SERVE_WAIT, PLAY, UPDATE.
REQ-013 IDLE: SERVE -> SERVE_WAIT; all other inputs ignored.
REQ-014 SERVE_WAIT: on VBLANK rising edge -> PLAY; dir_right=1, dir_down=1, hmag=1, vmag=1, HIT_COUNT=0, top_flag=0.
REQ-015 PLAY: each collision pulse sets a matching sticky event latch; PADDLE_ZONE latched with PADDLE_HIT (last pulse wins).
REQ-016 PLAY: on VBLANK rising edge (VBLANK=1, previous sample 0) -> UPDATE; pulses in that same cycle are included in this update.
REQ-017 UPDATE: lasts exactly one cycle, applies the latched events, clears all latches, then -> PLAY; output codes change on the cycle after UPDATE.
REQ-018 UPDATE: pulses arriving during UPDATE are latched for the next frame, not lost.
REQ-019 Vertical rule, in priority order: TOP -> dir_down=1 and top_flag=1; else PADDLE -> dir_down=0; else BRICK -> dir_down inverted; no event -> hold.
REQ-020 Paddle horizontal rule: zone0 -> left, hmag=3; zone1 -> left, hmag=1; zone2 -> right, hmag=1; zone3 -> right, hmag=3.
REQ-021 Wall rule overrides the paddle rule: WALL_L only -> dir_right=1; WALL_R only -> dir_right=0; both -> dir_right held; hmag unchanged.
REQ-022 Each UPDATE with a latched PADDLE SHALL increment HIT_COUNT by one, saturating at 15; multiple paddle pulses in one frame count once.
REQ-023 vmag after UPDATE: 3 if top_flag=1; else 2 if HIT_COUNT>=4; else 3 if HIT_COUNT>=12; else 1. HIT_COUNT>=12 takes precedence over >=4.
REQ-024 Codes: {X2,CX1,CX0} = dir_right ? 4+hmag : 3-hmag; {Y2,Y1,Y0} = dir_down ? 4+vmag : 3-vmag (3-bit unsigned, no overflow for mag 0..3).
REQ-025 MISS in PLAY or UPDATE -> IDLE next cycle; pending latches discarded; direction, magnitude and HIT_COUNT held.
REQ-026 SERVE outside IDLE SHALL be ignored.
REQ-027 BALL_EN=1 exactly in PLAY and UPDATE.
REQ-028 VBLANK edge detection SHALL use a registered copy of VBLANK; the copy SHALL reset to 1 so that a VBLANK already high at reset release does not count as an edge.

Reset
REQ-029 RESET SHALL take priority over every other input, including mid-UPDATE or mid-SERVE_WAIT.
REQ-030 Reset values: state IDLE, latches 0, dir_right=1, dir_down=1, hmag=1, vmag=1, top_flag=0, HIT_COUNT=0, BALL_EN=0, X code=5, Y code=5.

Verification
REQ-031 Reset, then SERVE, then VBLANK rise -> BALL_EN=1, X=5, Y=5, HIT_COUNT=0.
REQ-032 In PLAY: PADDLE_HIT with zone0 plus BRICK_HIT in the same frame, then VBLANK rise -> Y=2, X=0, HIT_COUNT=1.
REQ-033 Four frames each with a paddle hit (zone2) -> after the 4th UPDATE, Y=1 (up, vmag=2); after a TOP_HIT frame -> Y=7 (down, vmag=3).
REQ-034 WALL_L and WALL_R in the same frame as PADDLE_HIT zone3 -> direction held from before the frame, hmag=3.
REQ-035 MISS pulsed in the UPDATE cycle -> IDLE, BALL_EN=0; a later SERVE plus VBLANK rise restores X=5, Y=5.
REQ-036 RESET asserted during SERVE_WAIT while VBLANK is high -> IDLE; no PLAY entry until a new SERVE and a fresh VBLANK rise.

Source files
------------

// File: rtl/ball_direction_ctrl.sv
// Ball direction controller: latches collision events during a frame and
// applies them once per VBLANK rise to produce horizontal/vertical motion load codes.
module ball_direction_ctrl (
  input  logic       CLK_DRV,
  input  logic       RESET,
  input  logic       VBLANK,
  input  logic       SERVE,
  input  logic       MISS,
  input  logic       BRICK_HIT,
  input  logic       PADDLE_HIT,
  input  logic       TOP_HIT,
  input  logic       WALL_L,
  input  logic       WALL_R,
  input  logic [1:0] PADDLE_ZONE,
  output logic       CX0,
  output logic       CX1,
  output logic       X2,
  output logic       Y0,
  output logic       Y1,
  output logic       Y2,
  output logic       BALL_EN,
  output logic [3:0] HIT_COUNT
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_WAIT = 2'd1,
    PLAY       = 2'd2,
    UPDATE     = 2'd3
  } state_t;

  state_t      state_r;
  logic        vblank_prev_r;
  logic        lat_brick_r, lat_paddle_r, lat_top_r, lat_wall_l_r, lat_wall_r_r;
  logic [1:0]  lat_zone_r;
  logic        dir_right_r, dir_down_r, top_flag_r, ball_en_r;
  logic [1:0]  hmag_r, vmag_r;
  logic [3:0]  hit_count_r;
  logic [2:0]  x_code_r, y_code_r;

  logic        vblank_rise_s;
  logic        upd_dir_right_s, upd_dir_down_s, upd_top_flag_s;
  logic [1:0]  upd_hmag_s, upd_vmag_s;
  logic [3:0]  upd_hit_count_s;

  // Counter load code: moving positive is 4+mag, moving negative is 3-mag.
  function automatic logic [2:0] motion_code(input logic dir_pos, input logic [1:0] mag);
    if (dir_pos) begin
      motion_code = 3'd4 + {1'b0, mag};
    end else begin
      motion_code = 3'd3 - {1'b0, mag};
    end
  endfunction

  assign vblank_rise_s = VBLANK & ~vblank_prev_r;

  // Next motion parameters derived from the events latched over the frame.
  always_comb begin
    upd_hit_count_s = hit_count_r;
    upd_dir_down_s  = dir_down_r;
    upd_top_flag_s  = top_flag_r;
    upd_dir_right_s = dir_right_r;
    upd_hmag_s      = hmag_r;
    upd_vmag_s      = 2'd1;

    if (lat_paddle_r && (hit_count_r != 4'd15)) begin
      upd_hit_count_s = hit_count_r + 4'd1;
    end else begin
      upd_hit_count_s = hit_count_r;
    end

    if (lat_top_r) begin
      upd_dir_down_s = 1'b1;
      upd_top_flag_s = 1'b1;
    end else if (lat_paddle_r) begin
      upd_dir_down_s = 1'b0;
    end else if (lat_brick_r) begin
      upd_dir_down_s = ~dir_down_r;
    end else begin
      upd_dir_down_s = dir_down_r;
    end

    if (lat_paddle_r) begin
      case (lat_zone_r)
        2'd0:    begin upd_dir_right_s = 1'b0; upd_hmag_s = 2'd3; end
        2'd1:    begin upd_dir_right_s = 1'b0; upd_hmag_s = 2'd1; end
        2'd2:    begin upd_dir_right_s = 1'b1; upd_hmag_s = 2'd1; end
        2'd3:    begin upd_dir_right_s = 1'b1; upd_hmag_s = 2'd3; end
        default: begin upd_dir_right_s = dir_right_r; upd_hmag_s = hmag_r; end
      endcase
    end else begin
      upd_hmag_s = hmag_r;
    end

    // Walls decide direction over the paddle; both walls keep the pre-frame direction.
    if (lat_wall_l_r && lat_wall_r_r) begin
      upd_dir_right_s = dir_right_r;
    end else if (lat_wall_l_r) begin
      upd_dir_right_s = 1'b1;
    end else if (lat_wall_r_r) begin
      upd_dir_right_s = 1'b0;
    end else begin
      upd_dir_right_s = upd_dir_right_s;
    end

    if (upd_top_flag_s) begin
      upd_vmag_s = 2'd3;
    end else if (upd_hit_count_s >= 4'd12) begin
      upd_vmag_s = 2'd3;
    end else if (upd_hit_count_s >= 4'd4) begin
      upd_vmag_s = 2'd2;
    end else begin
      upd_vmag_s = 2'd1;
    end
  end

  // Control FSM, event latches, motion state and registered outputs.
  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      state_r       <= IDLE;
      vblank_prev_r <= 1'b1;
      lat_brick_r   <= 1'b0;
      lat_paddle_r  <= 1'b0;
      lat_top_r     <= 1'b0;
      lat_wall_l_r  <= 1'b0;
      lat_wall_r_r  <= 1'b0;
      lat_zone_r    <= 2'd0;
      dir_right_r   <= 1'b1;
      dir_down_r    <= 1'b1;
      hmag_r        <= 2'd1;
      vmag_r        <= 2'd1;
      top_flag_r    <= 1'b0;
      hit_count_r   <= 4'd0;
      ball_en_r     <= 1'b0;
      x_code_r      <= 3'd5;
      y_code_r      <= 3'd5;
    end else begin
      vblank_prev_r <= VBLANK;
      case (state_r)
        IDLE: begin
          if (SERVE) begin
            state_r <= SERVE_WAIT;
          end
        end
        SERVE_WAIT: begin
          if (vblank_rise_s) begin
            state_r      <= PLAY;
            ball_en_r    <= 1'b1;
            dir_right_r  <= 1'b1;
            dir_down_r   <= 1'b1;
            hmag_r       <= 2'd1;
            vmag_r       <= 2'd1;
            top_flag_r   <= 1'b0;
            hit_count_r  <= 4'd0;
            x_code_r     <= 3'd5;
            y_code_r     <= 3'd5;
            lat_brick_r  <= 1'b0;
            lat_paddle_r <= 1'b0;
            lat_top_r    <= 1'b0;
            lat_wall_l_r <= 1'b0;
            lat_wall_r_r <= 1'b0;
          end
        end
        PLAY: begin
          if (MISS) begin
            state_r      <= IDLE;
            ball_en_r    <= 1'b0;
            lat_brick_r  <= 1'b0;
            lat_paddle_r <= 1'b0;
            lat_top_r    <= 1'b0;
            lat_wall_l_r <= 1'b0;
            lat_wall_r_r <= 1'b0;
          end else begin
            lat_brick_r  <= lat_brick_r  | BRICK_HIT;
            lat_paddle_r <= lat_paddle_r | PADDLE_HIT;
            lat_top_r    <= lat_top_r    | TOP_HIT;
            lat_wall_l_r <= lat_wall_l_r | WALL_L;
            lat_wall_r_r <= lat_wall_r_r | WALL_R;
            lat_zone_r   <= PADDLE_HIT ? PADDLE_ZONE : lat_zone_r;
            if (vblank_rise_s) begin
              state_r <= UPDATE;
            end
          end
        end
        UPDATE: begin
          // Latches restart from this cycle's pulses so none are dropped.
          lat_brick_r  <= MISS ? 1'b0 : BRICK_HIT;
          lat_paddle_r <= MISS ? 1'b0 : PADDLE_HIT;
          lat_top_r    <= MISS ? 1'b0 : TOP_HIT;
          lat_wall_l_r <= MISS ? 1'b0 : WALL_L;
          lat_wall_r_r <= MISS ? 1'b0 : WALL_R;
          lat_zone_r   <= (PADDLE_HIT && !MISS) ? PADDLE_ZONE : lat_zone_r;
          if (MISS) begin
            state_r   <= IDLE;
            ball_en_r <= 1'b0;
          end else begin
            state_r     <= PLAY;
            dir_right_r <= upd_dir_right_s;
            dir_down_r  <= upd_dir_down_s;
            hmag_r      <= upd_hmag_s;
            vmag_r      <= upd_vmag_s;
            top_flag_r  <= upd_top_flag_s;
            hit_count_r <= upd_hit_count_s;
            x_code_r    <= motion_code(upd_dir_right_s, upd_hmag_s);
            y_code_r    <= motion_code(upd_dir_down_s, upd_vmag_s);
          end
        end
        default: begin
          state_r   <= IDLE;
          ball_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign {X2, CX1, CX0} = x_code_r;
  assign {Y2, Y1, Y0}   = y_code_r;
  assign BALL_EN        = ball_en_r;
  assign HIT_COUNT      = hit_count_r;

endmodule

// File: tb/tb_ball_direction_ctrl.sv
// Directed bench for ball_direction_ctrl: a velocity-level model predicts the
// outputs every cycle, and literal expectations pin the key scenarios.
module tb_ball_direction_ctrl;

  logic       CLK_DRV = 1'b0;
  logic       RESET, VBLANK, SERVE, MISS, BRICK_HIT, PADDLE_HIT, TOP_HIT, WALL_L, WALL_R;
  logic [1:0] PADDLE_ZONE;
  logic       CX0, CX1, X2, Y0, Y1, Y2, BALL_EN;
  logic [3:0] HIT_COUNT;

  ball_direction_ctrl dut (
    .CLK_DRV(CLK_DRV), .RESET(RESET), .VBLANK(VBLANK), .SERVE(SERVE), .MISS(MISS),
    .BRICK_HIT(BRICK_HIT), .PADDLE_HIT(PADDLE_HIT), .TOP_HIT(TOP_HIT),
    .WALL_L(WALL_L), .WALL_R(WALL_R), .PADDLE_ZONE(PADDLE_ZONE),
    .CX0(CX0), .CX1(CX1), .X2(X2), .Y0(Y0), .Y1(Y1), .Y2(Y2),
    .BALL_EN(BALL_EN), .HIT_COUNT(HIT_COUNT)
  );

  always #5 CLK_DRV = ~CLK_DRV;

  localparam logic [6:0] EV_SERVE = 7'b0000001;
  localparam logic [6:0] EV_BRICK = 7'b0000010;
  localparam logic [6:0] EV_PAD   = 7'b0000100;
  localparam logic [6:0] EV_TOP   = 7'b0001000;
  localparam logic [6:0] EV_WL    = 7'b0010000;
  localparam logic [6:0] EV_WR    = 7'b0100000;
  localparam logic [6:0] EV_MISS  = 7'b1000000;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 idle, 1 waiting for serve frame, 2 in play, 3 applying a frame.
  int m_mode = 0;
  bit m_vb_prev = 1'b1;
  bit p_brick, p_pad, p_top, p_wl, p_wr;
  int p_zone = 0;
  int sx = 1, hmag = 1, sy = 1, vmag = 1, hits = 0;
  bit topf = 1'b0;

  function automatic int code(input int s, input int m);
    return (s > 0) ? 4 + m : 3 - m;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clear_pend();
    p_brick = 0; p_pad = 0; p_top = 0; p_wl = 0; p_wr = 0;
  endtask

  task automatic take_pulses();
    if (BRICK_HIT)  p_brick = 1;
    if (PADDLE_HIT) begin p_pad = 1; p_zone = int'(PADDLE_ZONE); end
    if (TOP_HIT)    p_top = 1;
    if (WALL_L)     p_wl = 1;
    if (WALL_R)     p_wr = 1;
  endtask

  task automatic apply_frame();
    int old_sx;
    old_sx = sx;
    if (p_pad && hits < 15) hits++;
    if (p_top) begin sy = 1; topf = 1; end
    else if (p_pad) sy = -1;
    else if (p_brick) sy = -sy;
    if (p_pad) begin
      sx   = (p_zone >= 2) ? 1 : -1;
      hmag = (p_zone == 0 || p_zone == 3) ? 3 : 1;
    end
    if (p_wl && p_wr) sx = old_sx;
    else if (p_wl) sx = 1;
    else if (p_wr) sx = -1;
    vmag = topf ? 3 : (hits >= 12) ? 3 : (hits >= 4) ? 2 : 1;
  endtask

  task automatic model_step();
    bit rise;
    rise = VBLANK && !m_vb_prev;
    if (RESET) begin
      m_mode = 0; clear_pend(); p_zone = 0;
      sx = 1; hmag = 1; sy = 1; vmag = 1; hits = 0; topf = 0;
    end else begin
      case (m_mode)
        0: if (SERVE) m_mode = 1;
        1: if (rise) begin
             m_mode = 2; clear_pend();
             sx = 1; hmag = 1; sy = 1; vmag = 1; hits = 0; topf = 0;
           end
        2: if (MISS) begin m_mode = 0; clear_pend(); end
           else begin take_pulses(); if (rise) m_mode = 3; end
        default: if (MISS) begin m_mode = 0; clear_pend(); end
           else begin apply_frame(); clear_pend(); take_pulses(); m_mode = 2; end
      endcase
    end
    m_vb_prev = RESET ? 1'b1 : VBLANK;
  endtask

  // Advance one clock and compare every output to the model away from the edge.
  task automatic tick();
    model_step();
    @(posedge CLK_DRV);
    @(negedge CLK_DRV);
    check("ball_en", int'(BALL_EN), (m_mode >= 2) ? 1 : 0);
    check("x_code", int'({X2, CX1, CX0}), code(sx, hmag));
    check("y_code", int'({Y2, Y1, Y0}), code(sy, vmag));
    check("hit_count", int'(HIT_COUNT), hits);
  endtask

  task automatic clear_inputs();
    SERVE = 0; MISS = 0; BRICK_HIT = 0; PADDLE_HIT = 0; TOP_HIT = 0; WALL_L = 0; WALL_R = 0;
  endtask

  task automatic pulse(input logic [6:0] m, input logic [1:0] z);
    {MISS, WALL_R, WALL_L, TOP_HIT, PADDLE_HIT, BRICK_HIT, SERVE} = m;
    PADDLE_ZONE = z;
    tick();
    clear_inputs();
  endtask

  // Low cycle, rising cycle (enters the update), then the update cycle itself.
  task automatic frame_end();
    VBLANK = 0; tick();
    VBLANK = 1; tick();
    tick();
  endtask

  function automatic int xc();
    return int'({X2, CX1, CX0});
  endfunction
  function automatic int yc();
    return int'({Y2, Y1, Y0});
  endfunction

  initial begin
    clear_inputs();
    PADDLE_ZONE = 2'd0;
    RESET = 1; VBLANK = 1;
    repeat (3) tick();
    RESET = 0;
    repeat (2) tick();
    check("lit_reset_en", int'(BALL_EN), 0);
    check("lit_reset_x", xc(), 5);
    check("lit_reset_y", yc(), 5);
    check("lit_reset_hc", int'(HIT_COUNT), 0);

    pulse(EV_SERVE, 2'd0);
    frame_end();
    check("lit_serve_en", int'(BALL_EN), 1);
    check("lit_serve_x", xc(), 5);
    check("lit_serve_y", yc(), 5);
    check("lit_serve_hc", int'(HIT_COUNT), 0);

    pulse(EV_PAD | EV_BRICK, 2'd0);
    frame_end();
    check("lit_pad0_brick_x", xc(), 0);
    check("lit_pad0_brick_y", yc(), 2);
    check("lit_pad0_brick_hc", int'(HIT_COUNT), 1);

    for (int i = 0; i < 4; i++) begin
      pulse(EV_PAD, 2'd2);
      frame_end();
    end
    check("lit_four_pad_y", yc(), 1);
    check("lit_four_pad_x", xc(), 5);

    pulse(EV_TOP, 2'd0);
    frame_end();
    check("lit_top_y", yc(), 7);

    pulse(EV_PAD, 2'd1);
    frame_end();
    check("lit_pad1_x", xc(), 2);
    pulse(EV_WL | EV_WR | EV_PAD, 2'd3);
    frame_end();
    check("lit_both_walls_x", xc(), 0);
    pulse(EV_WL, 2'd0);
    frame_end();
    check("lit_wall_l_x", xc(), 7);
    pulse(EV_WR, 2'd0);
    frame_end();
    check("lit_wall_r_x", xc(), 0);

    // Brick on the rising cycle, paddle during the update cycle.
    VBLANK = 0; tick();
    VBLANK = 1; BRICK_HIT = 1; tick();
    clear_inputs(); PADDLE_HIT = 1; PADDLE_ZONE = 2'd3; tick();
    clear_inputs(); tick();
    check("lit_same_cycle_brick_y", yc(), 7);
    frame_end();
    check("lit_carried_pad_x", xc(), 7);
    check("lit_carried_pad_y", yc(), 0);

    pulse(EV_SERVE, 2'd0);
    tick();

    VBLANK = 0; tick();
    VBLANK = 1; tick();
    pulse(EV_MISS, 2'd0);
    check("lit_miss_update_en", int'(BALL_EN), 0);
    pulse(EV_SERVE, 2'd0);
    frame_end();
    check("lit_reserve_x", xc(), 5);
    check("lit_reserve_y", yc(), 5);

    for (int i = 0; i < 16; i++) begin
      pulse(EV_PAD, 2'd0);
      frame_end();
    end
    check("lit_sat_hc", int'(HIT_COUNT), 15);
    check("lit_sat_y", yc(), 0);

    pulse(EV_MISS, 2'd0);
    pulse(EV_SERVE, 2'd0);
    VBLANK = 0; tick();
    VBLANK = 1; RESET = 1; tick();
    RESET = 0; tick(); tick();
    check("lit_rst_wait_en", int'(BALL_EN), 0);
    frame_end();
    check("lit_no_serve_en", int'(BALL_EN), 0);
    pulse(EV_SERVE, 2'd0);
    frame_end();
    check("lit_after_rst_serve_en", int'(BALL_EN), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
